// File: rtl/attn_pkg.sv
// Shared Q1.6 constants and types for the attention pipeline (exp, softmax, MAC stages).
package attn_pkg;

    localparam int DATA_W = 8;
    localparam int FRAC_W = 6;
    localparam int Q_W    = FRAC_W + 1;

    localparam logic [DATA_W-1:0] ONE_Q16 = 8'd64;

    typedef enum logic [1:0] {
        ACCUM,
        DIV,
        EMIT
    } norm_state_t;

endpackage

// File: rtl/softmax_norm_if.sv
// Credit-based stream bundle between the exp stage, the softmax normaliser and its consumer.
interface softmax_norm_if #(
    parameter int DATA_W  = attn_pkg::DATA_W,
    parameter int MAX_ROW = 16
);
    localparam int CNT_W = $clog2(MAX_ROW + 1);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [CNT_W-1:0]  in_credit_ret;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_credit;

    modport master (
        output in_valid, in_data, in_last, out_credit,
        input  in_credit_ret, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_credit,
        output in_credit_ret, out_valid, out_data, out_last
    );

endinterface

// File: rtl/norm_div.sv
// Iterative restoring divider producing a 7-bit Q1.6 quotient: one load cycle plus 7 iterations.
// SOFTMAX_ROUND_EN adds a half-divisor bias (round-to-nearest) and clamps the result to 1.0.
module norm_div #(
    parameter int DATA_W = attn_pkg::DATA_W,
    parameter int SUM_W  = 11
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [DATA_W+attn_pkg::FRAC_W-1:0]   dividend,
    input  logic [SUM_W-1:0]                     divisor,
    output logic                                 done,
    output logic [attn_pkg::Q_W-1:0]             quot
);
    import attn_pkg::*;

    localparam int EXT_W = DATA_W + FRAC_W + 1;

    logic [EXT_W-1:0] dvd_ext;
    logic [SUM_W-1:0] rem_q;
    logic [SUM_W-1:0] dsr_q;
    logic [Q_W-1:0]   low_q;
    logic [Q_W-1:0]   quo_q;
    logic [2:0]       cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [SUM_W:0]   trial;
    logic             ge;

`ifdef SOFTMAX_ROUND_EN
    assign dvd_ext = EXT_W'(dividend) + EXT_W'(divisor >> 1);
`else
    assign dvd_ext = EXT_W'(dividend);
`endif

    // The quotient never exceeds 7 bits, so the upper dividend bits seed the remainder directly.
    assign trial = {rem_q, low_q[Q_W-1]};
    assign ge    = (trial >= {1'b0, dsr_q});

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            low_q  <= '0;
            quo_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                dsr_q <= divisor;
                rem_q <= SUM_W'(dvd_ext >> Q_W);
                low_q <= dvd_ext[Q_W-1:0];
                quo_q <= '0;
                cnt_q <= '0;
                if (divisor == '0) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    busy_q <= 1'b1;
                end
            end else if (busy_q) begin
                rem_q <= ge ? SUM_W'(trial - {1'b0, dsr_q}) : SUM_W'(trial);
                low_q <= {low_q[Q_W-2:0], 1'b0};
                quo_q <= {quo_q[Q_W-2:0], ge};
                cnt_q <= cnt_q + 3'd1;
                if (cnt_q == 3'(Q_W - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;

`ifdef SOFTMAX_ROUND_EN
    assign quot = (quo_q > Q_W'(ONE_Q16)) ? Q_W'(ONE_Q16) : quo_q;
`else
    assign quot = quo_q;
`endif

endmodule

// File: rtl/softmax_norm.sv
// Softmax normaliser: buffers a row of Q1.6 exponentials, sums them, emits each divided by the sum.
// Rounding mode is selected inside norm_div by SOFTMAX_ROUND_EN; latency is the same either way.
module softmax_norm #(
    parameter int MAX_ROW     = 16,
    parameter int OUT_CREDITS = 4,
    parameter int DATA_W      = attn_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    softmax_norm_if.slave bus,
    output logic          ovf_err
);
    import attn_pkg::*;

    localparam int IDX_W = $clog2(MAX_ROW);
    localparam int CNT_W = $clog2(MAX_ROW + 1);
    localparam int SUM_W = DATA_W - 1 + IDX_W;
    localparam int CRD_W = $clog2(OUT_CREDITS + 1);

    norm_state_t       state_q, state_d;
    logic [DATA_W-1:0] row_buf_q [MAX_ROW];
    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  row_len_q, row_len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CRD_W-1:0]  credit_q, credit_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] q_q;

    logic              accept;
    logic              emit;
    logic              is_last;
    logic              div_start;
    logic              div_done;
    logic [DATA_W-1:0] div_e;
    logic [Q_W-1:0]    div_quot;

    assign accept    = bus.in_valid && (state_q == ACCUM) && (wr_ptr_q != CNT_W'(MAX_ROW));
    assign emit      = (state_q == EMIT) && (credit_q != '0);
    assign is_last   = (CNT_W'(idx_q) == row_len_q - CNT_W'(1));
    assign div_start = (state_d == DIV) && (state_q != DIV);

    // The divider launches on the cycle that enters DIV, so a one-element row forwards in_data.
    assign div_e = (state_q == ACCUM && wr_ptr_q == '0) ? bus.in_data : row_buf_q[idx_d];

    norm_div #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ({div_e, {FRAC_W{1'b0}}}),
        .divisor  (sum_d),
        .done     (div_done),
        .quot     (div_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every combinational target gets a default first so no latch is inferred.
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && bus.in_last) state_d = DIV;
            DIV:     if (div_done) state_d = EMIT;
            EMIT:    if (emit) state_d = is_last ? ACCUM : DIV;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        bus.out_valid     = emit;
        bus.out_data      = emit ? q_q : '0;
        bus.out_last      = emit && is_last;
        bus.in_credit_ret = (emit && is_last) ? row_len_q : '0;
        ovf_err           = ovf_q;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        sum_d     = sum_q;
        row_len_d = row_len_q;
        idx_d     = idx_q;
        credit_d  = credit_q;
        ovf_d     = ovf_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + CNT_W'(1);
            sum_d    = sum_q + SUM_W'(bus.in_data);
            if (bus.in_last) begin
                row_len_d = wr_ptr_q + CNT_W'(1);
                idx_d     = '0;
            end
        end else if (bus.in_valid) begin
            ovf_d = 1'b1;
        end

        if (emit) begin
            if (is_last) begin
                wr_ptr_d = '0;
                sum_d    = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (bus.out_credit && !emit) begin
            if (credit_q == CRD_W'(OUT_CREDITS)) ovf_d = 1'b1;
            else                                 credit_d = credit_q + CRD_W'(1);
        end else if (emit && !bus.out_credit) begin
            credit_d = credit_q - CRD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            sum_q     <= '0;
            row_len_q <= '0;
            idx_q     <= '0;
            credit_q  <= CRD_W'(OUT_CREDITS);
            ovf_q     <= 1'b0;
            q_q       <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            sum_q     <= sum_d;
            row_len_q <= row_len_d;
            idx_q     <= idx_d;
            credit_q  <= credit_d;
            ovf_q     <= ovf_d;
            if (div_done) q_q <= DATA_W'(div_quot);
        end
    end

    // NOTE: the row buffer has no reset; wr_ptr and row_len keep stale entries from being read.
    always_ff @(posedge clk) begin
        if (accept) row_buf_q[wr_ptr_q[IDX_W-1:0]] <= bus.in_data;
    end

endmodule

// File: tb/tb_softmax_norm.sv
// Self-checking bench for softmax_norm: directed row table, credit/overflow/reset sequences, random rows.
// Expected quotients follow SOFTMAX_ROUND_EN when it is defined.
module tb_softmax_norm;

    localparam int MAX_ROW     = 16;
    localparam int OUT_CREDITS = 4;
    localparam int TB_DW       = 8;
`ifdef SOFTMAX_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic clk;
    logic rst;
    logic ovf_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    softmax_norm_if #(.DATA_W(TB_DW), .MAX_ROW(MAX_ROW)) bus ();

    softmax_norm #(
        .MAX_ROW     (MAX_ROW),
        .OUT_CREDITS (OUT_CREDITS),
        .DATA_W      (TB_DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ovf_err (ovf_err)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] last;
        logic [31:0] cret;
        int          cyc;
    } beat_t;

    typedef struct {
        int len;
        int e[4];
        int q[4];
    } vec_t;

    beat_t beats[$];
    vec_t  vecs[7];
    int    n_pass = 0;
    int    n_total = 0;
    int    cyc = 0;
    bit    auto_credit = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    // Reference: probability = e * 64 / row sum, truncated or rounded, 0 when the row sums to 0.
    function automatic int ref_q(input int e, input int sum);
        int q;
        if (sum == 0) return 0;
        if (RND != 0) begin
            q = (e * 64 + sum / 2) / sum;
            return (q > 64) ? 64 : q;
        end
        return (e * 64) / sum;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.out_valid === 1'b1)
            beats.push_back('{data: 32'(bus.out_data), last: 32'(bus.out_last),
                              cret: 32'(bus.in_credit_ret), cyc: cyc});
        else if (bus.in_credit_ret !== '0)
            check("cret_without_beat", 32'(bus.in_credit_ret), 0);
        if (auto_credit) bus.out_credit = bus.out_valid;
    endtask

    task automatic send_row(input int vals[$], input bit with_last);
        for (int i = 0; i < vals.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = TB_DW'(vals[i]);
            bus.in_last  = with_last && (i == vals.size() - 1);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        while (beats.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, "_count"}, beats.size(), n);
    endtask

    task automatic check_row(input int vals[$], input int expq[$], input string tag);
        int n;
        int sum;
        n   = vals.size();
        sum = 0;
        foreach (vals[i]) sum += vals[i];
        wait_beats(n, n * 12 + 20, tag);
        for (int i = 0; i < n && i < beats.size(); i++) begin
            check({tag, "_data"}, beats[i].data, expq[i]);
            check({tag, "_last"}, beats[i].last, (i == n - 1) ? 1 : 0);
            check({tag, "_cret"}, beats[i].cret, (i == n - 1) ? n : 0);
            if (i > 0) check({tag, "_gap"}, beats[i].cyc - beats[i-1].cyc, (sum == 0) ? 2 : 9);
        end
        beats.delete();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        beats.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int vals[$];
        int expq[$];

        vecs[0] = '{len: 2, e: '{64, 64, 0, 0},  q: '{32, 32, 0, 0}};
        vecs[1] = '{len: 3, e: '{0, 0, 0, 0},    q: '{0, 0, 0, 0}};
        vecs[2] = '{len: 2, e: '{1, 2, 0, 0},    q: '{21, (RND != 0) ? 43 : 42, 0, 0}};
        vecs[3] = '{len: 1, e: '{64, 0, 0, 0},   q: '{64, 0, 0, 0}};
        vecs[4] = '{len: 1, e: '{127, 0, 0, 0},  q: '{64, 0, 0, 0}};
        vecs[5] = '{len: 2, e: '{127, 1, 0, 0},  q: '{(RND != 0) ? 64 : 63, (RND != 0) ? 1 : 0, 0, 0}};
        vecs[6] = '{len: 4, e: '{5, 5, 5, 5},    q: '{16, 16, 16, 16}};

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.out_credit = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data",  32'(bus.out_data), 0);
        check("rst_out_last",  32'(bus.out_last), 0);
        check("rst_cret",      32'(bus.in_credit_ret), 0);
        check("rst_ovf",       32'(ovf_err), 0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 7; k++) begin
            vals.delete();
            expq.delete();
            for (int i = 0; i < vecs[k].len; i++) begin
                vals.push_back(vecs[k].e[i]);
                expq.push_back(vecs[k].q[i]);
            end
            send_row(vals, 1'b1);
            check_row(vals, expq, $sformatf("vec%0d", k));
        end
        check("table_ovf", 32'(ovf_err), 0);

        // Output credits exhausted: four beats, stall, then two credits release the rest.
        auto_credit    = 1'b0;
        bus.out_credit = 1'b0;
        vals = '{10, 10, 10, 10, 10, 10};
        send_row(vals, 1'b1);
        repeat (60) tick();
        check("credit_stall_beats", beats.size(), 4);
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            check("credit_stall_data", beats[i].data, ref_q(10, 60));
            check("credit_stall_last", beats[i].last, 0);
        end
        repeat (20) tick();
        check("credit_stall_hold", beats.size(), 4);
        beats.delete();
        repeat (2) begin
            bus.out_credit = 1'b1;
            tick();
            bus.out_credit = 1'b0;
            tick();
        end
        wait_beats(2, 40, "credit_resume");
        if (beats.size() == 2) begin
            check("credit_resume_data", beats[1].data, ref_q(10, 60));
            check("credit_resume_last0", beats[0].last, 0);
            check("credit_resume_last1", beats[1].last, 1);
            check("credit_resume_cret", beats[1].cret, 6);
        end
        beats.delete();
        repeat (OUT_CREDITS) begin
            bus.out_credit = 1'b1;
            tick();
            bus.out_credit = 1'b0;
            tick();
        end
        check("credit_refill_ovf", 32'(ovf_err), 0);
        bus.out_credit = 1'b1;
        tick();
        bus.out_credit = 1'b0;
        tick();
        check("credit_saturate_ovf", 32'(ovf_err), 1);
        auto_credit = 1'b1;
        do_reset();
        check("credit_rst_ovf", 32'(ovf_err), 0);

        // Row buffer overflow: the 17th beat is dropped and the flag is sticky.
        vals.delete();
        for (int i = 0; i < MAX_ROW; i++) vals.push_back(3);
        send_row(vals, 1'b0);
        check("full_row_ovf", 32'(ovf_err), 0);
        vals = '{3};
        send_row(vals, 1'b0);
        check("beat17_ovf", 32'(ovf_err), 1);
        repeat (5) tick();
        check("beat17_sticky", 32'(ovf_err), 1);
        check("beat17_no_out", beats.size(), 0);
        do_reset();
        check("beat17_rst_ovf", 32'(ovf_err), 0);

        // A beat arriving while dividing is dropped; the pending row still completes.
        vals = '{64};
        send_row(vals, 1'b1);
        vals = '{5};
        send_row(vals, 1'b1);
        check("drop_in_div_ovf", 32'(ovf_err), 1);
        vals = '{64};
        expq = '{64};
        check_row(vals, expq, "drop_in_div");
        do_reset();

        // Reset while stalled in EMIT of a 5-element row.
        auto_credit    = 1'b0;
        bus.out_credit = 1'b0;
        vals = '{10, 20, 30, 40, 50};
        send_row(vals, 1'b1);
        wait_beats(4, 80, "emit_rst_pre");
        repeat (15) tick();
        rst = 1'b1;
        tick();
        check("emit_rst_valid", 32'(bus.out_valid), 0);
        check("emit_rst_cret",  32'(bus.in_credit_ret), 0);
        check("emit_rst_ovf",   32'(ovf_err), 0);
        rst = 1'b0;
        beats.delete();
        auto_credit = 1'b1;
        tick();
        vals = '{64};
        expq = '{64};
        send_row(vals, 1'b1);
        check_row(vals, expq, "post_rst");

        // Random rows against the arithmetic reference.
        for (int r = 0; r < 10; r++) begin
            int len;
            int sum;
            len = (r < 3) ? MAX_ROW : int'($urandom_range(1, MAX_ROW));
            vals.delete();
            expq.delete();
            sum = 0;
            for (int i = 0; i < len; i++) begin
                int v;
                if (r == 1)      v = 0;
                else if (r == 2) v = 127;
                else             v = int'($urandom_range(0, 127));
                vals.push_back(v);
                sum += v;
            end
            foreach (vals[i]) expq.push_back(ref_q(vals[i], sum));
            send_row(vals, 1'b1);
            check_row(vals, expq, "rand");
        end
        check("final_ovf", 32'(ovf_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
